// File: rtl/jk_flip_flop.sv
// Bank of independent edge-triggered JK flip-flops with true and complementary outputs.
// Each bit holds, resets, sets or toggles on the rising clock edge according to its J/K pair.
module jk_flip_flop #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] q_next;

    // Explicit per-bit decode rather than the characteristic equation, so that a set
    // or reset resolves an unknown q in simulation instead of propagating it.
    always_comb begin
        q_next = q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
                2'b00:   q_next[i] = q[i];
                2'b01:   q_next[i] = 1'b0;
                2'b10:   q_next[i] = 1'b1;
                2'b11:   q_next[i] = ~q[i];
                default: q_next[i] = q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else begin
            q <= q_next;
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed, table-driven check of jk_flip_flop at WIDTH=1 and WIDTH=4.
module tb_jk_flip_flop;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       j1, k1;
    logic       q1, qbar1;
    logic [3:0] j4, k4;
    logic [3:0] q4, qbar4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    jk_flip_flop #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .j    (j1),
        .k    (k1),
        .q    (q1),
        .qbar (qbar1)
    );

    jk_flip_flop #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .j    (j4),
        .k    (k4),
        .q    (q4),
        .qbar (qbar4)
    );

    typedef struct {
        logic rst_n;
        logic j;
        logic k;
        logic q_exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst_n, j, k, expected q after the edge
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0};  // reset ignores toggle request
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};  // set
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1};  // hold x3
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0};  // reset via K
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0};  // hold
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1};  // toggle x4
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0};  // reset mid-toggle
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1};  // toggling resumes
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b1;
        j1 = 1'b0; k1 = 1'b0;
        j4 = '0;   k4 = '0;
        #1;

        for (int i = 0; i < 15; i++) begin
            rst_n = vecs[i].rst_n;
            j1    = vecs[i].j;
            k1    = vecs[i].k;
            tick();
            check($sformatf("vec%0d_q", i),    {3'b0, q1},    {3'b0, vecs[i].q_exp});
            check($sformatf("vec%0d_qbar", i), {3'b0, qbar1}, {3'b0, ~vecs[i].q_exp});
        end

        // Inputs changed between edges: q stable until the next edge
        j1 = 1'b0; k1 = 1'b1;
        tick();
        check("clear_q", {3'b0, q1}, 4'b0000);
        #2 j1 = 1'b1; k1 = 1'b0;
        #2 j1 = 1'b0; k1 = 1'b0;
        tick();
        check("pulse_between_edges_q", {3'b0, q1}, 4'b0000);
        j1 = 1'b1;
        #3;
        check("stable_before_edge_q", {3'b0, q1}, 4'b0000);
        tick();
        check("one_edge_latency_q", {3'b0, q1}, 4'b0001);
        j1 = 1'b0;

        // WIDTH=4 per-bit independence
        rst_n = 1'b0; j4 = 4'b1111; k4 = 4'b1111;
        tick();
        check("w4_reset_q",    q4,    4'b0000);
        check("w4_reset_qbar", qbar4, 4'b1111);
        rst_n = 1'b1; j4 = 4'b0101; k4 = 4'b1010;
        tick();
        check("w4_preload_q", q4, 4'b0101);
        j4 = 4'b1100; k4 = 4'b1010;
        tick();
        check("w4_mixed_q",    q4,    4'b1101);
        check("w4_mixed_qbar", qbar4, 4'b0010);
        j4 = 4'b1111; k4 = 4'b1111;
        tick();
        check("w4_toggle_q", q4, 4'b0010);
        rst_n = 1'b0;
        tick();
        check("w4_reset_toggle_q", q4, 4'b0000);
        rst_n = 1'b1;
        tick();
        check("w4_resume_toggle_q", q4, 4'b1111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
